// File: rtl/memory_manager_pkg.sv
// rtl/memory_manager_pkg.sv - derived geometry helpers and FSM encoding shared by the burst memory managers
package memory_manager_pkg;

   localparam int DEFAULT_WORD_BIT_WIDTH    = 64;
   localparam int DEFAULT_MESSAGE_BIT_WIDTH = 32;

   function automatic int calc_num_messages_in_word(input int word_w, input int msg_w);
      return word_w / msg_w;
   endfunction

   // a row holding a single message needs no slice bits in the message address
   function automatic int calc_bits_for_within_row(input int num_msgs);
      return (num_msgs > 1) ? $clog2(num_msgs) : 0;
   endfunction

   // width of a shift amount able to reach every bit position of a row
   function automatic int calc_required_shift(input int word_w);
      return $clog2(word_w) + 1;
   endfunction

   localparam int NUM_MESSAGES_IN_WORD =
      calc_num_messages_in_word(DEFAULT_WORD_BIT_WIDTH, DEFAULT_MESSAGE_BIT_WIDTH);
   localparam int BITS_FOR_WITHIN_ROW  = calc_bits_for_within_row(NUM_MESSAGES_IN_WORD);
   localparam int REQUIRED_SHIFT       = calc_required_shift(DEFAULT_WORD_BIT_WIDTH);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE      = 2'd1,
      READ_ISSUE = 2'd2,
      READ_WAIT  = 2'd3
   } mm_state_e;

endpackage

// File: rtl/message_slicer.sv
// rtl/message_slicer.sv - places a message into its slice of a row and pulls a message out of a row
module message_slicer
   import memory_manager_pkg::*;
#(
   parameter int WORD_BIT_WIDTH    = 64,
   parameter int MESSAGE_BIT_WIDTH = 32,
   parameter int SLICE_BIT_WIDTH   = 1
)
(
   input  logic [SLICE_BIT_WIDTH-1:0]   insert_slice,
   input  logic [MESSAGE_BIT_WIDTH-1:0] message_in,
   output logic [WORD_BIT_WIDTH-1:0]    word_data,
   output logic [WORD_BIT_WIDTH-1:0]    word_mask,
   input  logic [SLICE_BIT_WIDTH-1:0]   extract_slice,
   input  logic [WORD_BIT_WIDTH-1:0]    word_in,
   output logic [MESSAGE_BIT_WIDTH-1:0] message_out
);

   localparam int SHIFT_W = calc_required_shift(WORD_BIT_WIDTH);
   localparam logic [SHIFT_W-1:0]        MSG_STEP = SHIFT_W'(MESSAGE_BIT_WIDTH);
   localparam logic [WORD_BIT_WIDTH-1:0] MSG_ONES = WORD_BIT_WIDTH'({MESSAGE_BIT_WIDTH{1'b1}});

   logic [SHIFT_W-1:0] insert_shift;
   logic [SHIFT_W-1:0] extract_shift;

   // slice index times message width gives the bit offset of the slice in the row
   always_comb begin
      insert_shift  = SHIFT_W'(insert_slice) * MSG_STEP;
      extract_shift = SHIFT_W'(extract_slice) * MSG_STEP;
      word_data     = WORD_BIT_WIDTH'(message_in) << insert_shift;
      word_mask     = MSG_ONES << insert_shift;
      message_out   = MESSAGE_BIT_WIDTH'(word_in >> extract_shift);
   end

endmodule

// File: rtl/memory_manager_burst.sv
// rtl/memory_manager_burst.sv - SPI burst engine sharing one SRAM port with the control datapath
module memory_manager_burst
   import memory_manager_pkg::*;
#(
   parameter int WORD_BIT_WIDTH          = 64,
   parameter int ADDRESS_BIT_WIDTH       = 9,
   parameter int START_ADDRESS_BIT_WIDTH = 14,
   parameter int MESSAGE_BIT_WIDTH       = 32,
   parameter int MEMORY_READ_LATENCY     = 1,
   parameter int BURST_LENGTH_BIT_WIDTH  = 8
)
(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               is_code_for_this_memory,
   input  logic                               cmd_valid,
   output logic                               cmd_ready,
   input  logic                               cmd_write,
   input  logic [START_ADDRESS_BIT_WIDTH-1:0] cmd_start_address,
   input  logic [BURST_LENGTH_BIT_WIDTH-1:0]  cmd_burst_length,
   input  logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_in,
   input  logic                               spi_data_in_valid,
   output logic                               spi_data_in_ready,
   output logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_out,
   output logic                               spi_data_out_valid,
   output logic                               burst_done,
   input  logic [WORD_BIT_WIDTH-1:0]          memory_data_out,
   input  logic                               control_chip_select,
   input  logic                               control_write_enable,
   input  logic [ADDRESS_BIT_WIDTH-1:0]       control_address,
   input  logic [WORD_BIT_WIDTH-1:0]          control_data_in,
   input  logic [WORD_BIT_WIDTH-1:0]          control_mask,
   output logic                               chip_select,
   output logic                               write_enable,
   output logic [ADDRESS_BIT_WIDTH-1:0]       address,
   output logic [WORD_BIT_WIDTH-1:0]          data_in,
   output logic [WORD_BIT_WIDTH-1:0]          mask
);

   localparam int NUM_MSGS        = calc_num_messages_in_word(WORD_BIT_WIDTH, MESSAGE_BIT_WIDTH);
   localparam int WITHIN_ROW_BITS = calc_bits_for_within_row(NUM_MSGS);
   localparam int SLICE_W         = (WITHIN_ROW_BITS > 0) ? WITHIN_ROW_BITS : 1;
   localparam int MSG_ADDR_W      = ADDRESS_BIT_WIDTH + WITHIN_ROW_BITS;
   localparam int WAIT_W          = (MEMORY_READ_LATENCY > 1) ? $clog2(MEMORY_READ_LATENCY) : 1;
   localparam logic [SLICE_W-1:0] SLICE_MASK = SLICE_W'((1 << WITHIN_ROW_BITS) - 1);

   if (WORD_BIT_WIDTH % MESSAGE_BIT_WIDTH != 0) begin : g_bad_word_width
      $error("WORD_BIT_WIDTH must be a multiple of MESSAGE_BIT_WIDTH");
   end
   if (START_ADDRESS_BIT_WIDTH < MSG_ADDR_W) begin : g_bad_start_width
      $error("START_ADDRESS_BIT_WIDTH too narrow for row plus slice bits");
   end
   if (MEMORY_READ_LATENCY < 1) begin : g_bad_latency
      $error("MEMORY_READ_LATENCY must be at least 1");
   end
   if (START_ADDRESS_BIT_WIDTH > MSG_ADDR_W) begin : g_unused_addr
      logic unused_high_address_bits;
      assign unused_high_address_bits = ^cmd_start_address[START_ADDRESS_BIT_WIDTH-1:MSG_ADDR_W];
   end

   mm_state_e                     state, state_next;
   logic [MSG_ADDR_W-1:0]         msg_addr;
   logic [BURST_LENGTH_BIT_WIDTH-1:0] remaining;
   logic [WAIT_W-1:0]             wait_count;
   logic [SLICE_W-1:0]            read_slice;
   logic [ADDRESS_BIT_WIDTH-1:0]  cur_row;
   logic [SLICE_W-1:0]            cur_slice;
   logic [WORD_BIT_WIDTH-1:0]     insert_data, insert_mask;
   logic [MESSAGE_BIT_WIDTH-1:0]  extracted_message;
   logic                          slot_free, cmd_accept, write_beat, read_issue, read_final;

   assign cur_row   = msg_addr[MSG_ADDR_W-1 -: ADDRESS_BIT_WIDTH];
   assign cur_slice = SLICE_W'(msg_addr) & SLICE_MASK;
   assign slot_free = ~control_chip_select;

   message_slicer #(
      .WORD_BIT_WIDTH    (WORD_BIT_WIDTH),
      .MESSAGE_BIT_WIDTH (MESSAGE_BIT_WIDTH),
      .SLICE_BIT_WIDTH   (SLICE_W)
   ) u_slicer (
      .insert_slice  (cur_slice),
      .message_in    (spi_data_in),
      .word_data     (insert_data),
      .word_mask     (insert_mask),
      .extract_slice (read_slice),
      .word_in       (memory_data_out),
      .message_out   (extracted_message)
   );

   // state register; reset abandons any burst in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // next state and SRAM bus steering; control owns the bus whenever it asks
   always_comb begin
      state_next        = state;
      cmd_ready         = 1'b0;
      spi_data_in_ready = 1'b0;
      cmd_accept        = 1'b0;
      write_beat        = 1'b0;
      read_issue        = 1'b0;
      read_final        = 1'b0;
      chip_select       = control_chip_select;
      write_enable      = control_write_enable;
      address           = control_address;
      data_in           = control_data_in;
      mask              = control_mask;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && is_code_for_this_memory) begin
               cmd_accept = 1'b1;
               state_next = cmd_write ? WRITE : READ_ISSUE;
            end
         end
         WRITE: begin
            if (spi_data_in_valid && slot_free) begin
               spi_data_in_ready = 1'b1;
               write_beat        = 1'b1;
               chip_select       = 1'b1;
               write_enable      = 1'b1;
               address           = cur_row;
               data_in           = insert_data;
               mask              = insert_mask;
               if (remaining == '0) state_next = IDLE;
            end
         end
         READ_ISSUE: begin
            if (slot_free) begin
               read_issue   = 1'b1;
               chip_select  = 1'b1;
               write_enable = 1'b0;
               address      = cur_row;
               data_in      = '0;
               mask         = '0;
               state_next   = READ_WAIT;
            end
         end
         READ_WAIT: begin
            if (wait_count == WAIT_W'(MEMORY_READ_LATENCY - 1)) begin
               read_final = 1'b1;
               state_next = (remaining == '0) ? IDLE : READ_ISSUE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // burst bookkeeping: address and beat count advance once per completed beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         msg_addr           <= '0;
         remaining          <= '0;
         wait_count         <= '0;
         read_slice         <= '0;
         spi_data_out       <= '0;
         spi_data_out_valid <= 1'b0;
         burst_done         <= 1'b0;
      end else begin
         spi_data_out_valid <= 1'b0;
         burst_done         <= 1'b0;
         if (cmd_accept) begin
            msg_addr  <= cmd_start_address[MSG_ADDR_W-1:0];
            remaining <= cmd_burst_length;
         end
         if (read_issue) begin
            read_slice <= cur_slice;
            wait_count <= '0;
         end else if (state == READ_WAIT) begin
            wait_count <= wait_count + 1'b1;
         end
         if (read_final) begin
            spi_data_out       <= extracted_message;
            spi_data_out_valid <= 1'b1;
         end
         if (write_beat || read_final) begin
            msg_addr <= msg_addr + 1'b1;
            if (remaining == '0) burst_done <= 1'b1;
            else                 remaining  <= remaining - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_memory_manager_burst.sv
// tb/tb_memory_manager_burst.sv - self-checking bench for memory_manager_burst
module tb_memory_manager_burst;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        is_code_for_this_memory = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_write = 1'b0;
   logic [13:0] cmd_start_address = '0;
   logic [7:0]  cmd_burst_length = '0;
   logic [31:0] spi_data_in = '0;
   logic        spi_data_in_valid = 1'b0;
   logic        spi_data_in_ready;
   logic [31:0] spi_data_out;
   logic        spi_data_out_valid;
   logic        burst_done;
   logic [63:0] memory_data_out;
   logic        control_chip_select = 1'b0;
   logic        control_write_enable = 1'b0;
   logic [8:0]  control_address = '0;
   logic [63:0] control_data_in = '0;
   logic [63:0] control_mask = '0;
   logic        chip_select;
   logic        write_enable;
   logic [8:0]  address;
   logic [63:0] data_in;
   logic [63:0] mask;

   memory_manager_burst #(.MEMORY_READ_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n),
      .is_code_for_this_memory(is_code_for_this_memory),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_start_address(cmd_start_address), .cmd_burst_length(cmd_burst_length),
      .spi_data_in(spi_data_in), .spi_data_in_valid(spi_data_in_valid),
      .spi_data_in_ready(spi_data_in_ready),
      .spi_data_out(spi_data_out), .spi_data_out_valid(spi_data_out_valid),
      .burst_done(burst_done), .memory_data_out(memory_data_out),
      .control_chip_select(control_chip_select), .control_write_enable(control_write_enable),
      .control_address(control_address), .control_data_in(control_data_in),
      .control_mask(control_mask),
      .chip_select(chip_select), .write_enable(write_enable), .address(address),
      .data_in(data_in), .mask(mask)
   );

   always #5 clk = ~clk;

   // SRAM macro model: masked writes, reads returned L cycles after issue
   logic [63:0] sram [512];
   logic [63:0] rd_pipe [L];
   always @(posedge clk) begin
      if (chip_select && write_enable)
         sram[address] <= (sram[address] & ~mask) | (data_in & mask);
      for (int i = L - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      if (chip_select && !write_enable) rd_pipe[0] <= sram[address];
   end
   assign memory_data_out = rd_pipe[L-1];

   typedef struct packed {
      logic [8:0]  row;
      logic [63:0] data;
      logic [63:0] mask;
   } wr_t;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int done_count = 0;
   int done_base = 0;
   int rd_issue_cnt = 0;
   int last_valid_cyc = -1;
   int first_valid_cyc = -1;
   int accept_cyc = 0;
   wr_t         exp_wr[$];
   logic [8:0]  exp_rd_row[$];
   logic [31:0] exp_rd[$];
   logic [31:0] beat_q[$];
   logic [8:0]  log_row[$];
   logic [63:0] log_mask[$];
   logic [31:0] msg_mem [1024];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // message-addressed view of what an SPI write of data d at message address a must do to the SRAM
   function automatic wr_t model_write(input logic [9:0] a, input logic [31:0] d);
      wr_t w;
      int  s;
      s      = int'(a[0]);
      w.row  = 9'(a >> 1);
      w.data = {32'h0, d} << (32 * s);
      w.mask = {32'h0, 32'hFFFF_FFFF} << (32 * s);
      return w;
   endfunction

   // compare process: every bus cycle and every read beat against the model queues
   always @(negedge clk) begin
      if (rst_n) begin
         if (burst_done) done_count++;
         if (control_chip_select) begin
            check("ctl_pass_cs_we_addr", {chip_select, write_enable, address},
                  {control_chip_select, control_write_enable, control_address});
            check("ctl_pass_data", data_in, control_data_in);
            check("ctl_pass_mask", mask, control_mask);
            check("stall_ready_low", spi_data_in_ready, 1'b0);
         end else begin
            check("ready_iff_spi_write", spi_data_in_ready, chip_select & write_enable);
            if (chip_select && write_enable) begin
               check("spi_write_expected", exp_wr.size() != 0, 1'b1);
               if (exp_wr.size() != 0) begin
                  wr_t w;
                  w = exp_wr.pop_front();
                  check("wr_row", address, w.row);
                  check("wr_data", data_in, w.data);
                  check("wr_mask", mask, w.mask);
                  log_row.push_back(address);
                  log_mask.push_back(mask);
               end
            end else if (chip_select) begin
               check("spi_read_expected", exp_rd_row.size() != 0, 1'b1);
               if (exp_rd_row.size() != 0) check("rd_row", address, exp_rd_row.pop_front());
               rd_issue_cnt++;
            end
         end
         if (spi_data_out_valid) begin
            check("read_beat_expected", exp_rd.size() != 0, 1'b1);
            if (exp_rd.size() != 0) check("rd_data", spi_data_out, exp_rd.pop_front());
            if (last_valid_cyc >= 0) check("beat_spacing_ge3", (cyc - last_valid_cyc) >= 3, 1'b1);
            last_valid_cyc = cyc;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
         end
      end
   end

   task automatic issue_cmd(input logic wr, input logic [13:0] a, input logic [7:0] len);
      cmd_valid = 1'b1; is_code_for_this_memory = 1'b1; cmd_write = wr;
      cmd_start_address = a; cmd_burst_length = len;
      @(negedge clk);
      check("cmd_ready_idle", cmd_ready, 1'b1);
      accept_cyc = cyc;
      @(posedge clk); #1;
      cmd_valid = 1'b0; is_code_for_this_memory = 1'b0;
   endtask

   task automatic write_burst(input logic [13:0] start, input int n, input int stall_at, input int busy_at);
      int  waited, stall_left;
      bit  got;
      logic [9:0] a;
      for (int i = 0; i < n; i++) begin
         a = 10'(start + 14'(i));
         exp_wr.push_back(model_write(a, beat_q[i]));
         msg_mem[a] = beat_q[i];
      end
      issue_cmd(1'b1, start, 8'(n - 1));
      for (int k = 0; k < n; k++) begin
         spi_data_in = beat_q[k]; spi_data_in_valid = 1'b1;
         stall_left = (k == stall_at) ? 5 : 0;
         if (k == busy_at) begin
            cmd_valid = 1'b1; is_code_for_this_memory = 1'b1; cmd_write = 1'b0;
         end
         waited = 0; got = 1'b0;
         while (!got && waited < 50) begin
            if (stall_left > 0) begin
               control_chip_select = 1'b1; control_write_enable = 1'b1;
               control_address = 9'h100; control_data_in = 64'h0123_4567_89AB_CDEF;
               control_mask = 64'hFFFF_0000_FFFF_0000;
               stall_left--;
            end else begin
               control_chip_select = 1'b0; control_write_enable = 1'b0;
            end
            @(negedge clk);
            if (k == busy_at && waited == 0) check("busy_cmd_ready_low", cmd_ready, 1'b0);
            if (spi_data_in_ready) got = 1'b1;
            else begin
               waited++;
               @(posedge clk); #1;
            end
         end
         check("beat_accepted", got, 1'b1);
         if (k == stall_at) check("stall_cycles", waited, 5);
         @(posedge clk); #1;
         cmd_valid = 1'b0; is_code_for_this_memory = 1'b0;
      end
      spi_data_in_valid = 1'b0;
      @(negedge clk);
      check("write_burst_done", burst_done, 1'b1);
      check("cmd_ready_after_write", cmd_ready, 1'b1);
      check("write_queue_drained", exp_wr.size(), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("burst_done_single", burst_done, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic start_read(input logic [13:0] start, input int n);
      logic [9:0] a;
      for (int i = 0; i < n; i++) begin
         a = 10'(start + 14'(i));
         exp_rd.push_back(msg_mem[a]);
         exp_rd_row.push_back(9'(a >> 1));
      end
      last_valid_cyc = -1; first_valid_cyc = -1;
      done_base = done_count;
      issue_cmd(1'b0, start, 8'(n - 1));
   endtask

   task automatic finish_read();
      int w;
      w = 0;
      while (exp_rd.size() != 0 && w < 200) begin
         @(negedge clk); #1;
         w++;
      end
      check("read_beats_all_seen", exp_rd.size(), 0);
      @(posedge clk); #1;
      @(negedge clk); #1;
      check("read_burst_done_once", done_count - done_base, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      int base, w;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, w;
      // reset values while held
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_spi_data_out", spi_data_out, 32'h0);
      check("rst_out_valid", spi_data_out_valid, 1'b0);
      check("rst_burst_done", burst_done, 1'b0);
      check("rst_in_ready", spi_data_in_ready, 1'b0);
      check("rst_cs_pass", chip_select, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // command for another memory is ignored
      cmd_valid = 1'b1; is_code_for_this_memory = 1'b0; cmd_write = 1'b1;
      cmd_start_address = 14'h005; cmd_burst_length = 8'd0;
      repeat (3) begin
         @(negedge clk);
         check("ignored_cmd_ready", cmd_ready, 1'b1);
         check("ignored_cmd_cs", chip_select, 1'b0);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      check("ignored_cmd_still_idle", cmd_ready, 1'b1);
      @(posedge clk); #1;

      // write burst 0x003, four beats, with a read command probed while busy
      beat_q = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
      log_row.delete(); log_mask.delete();
      write_burst(14'h003, 4, -1, 1);
      check("log_count", log_row.size(), 4);
      if (log_row.size() == 4) begin
         check("t1_row0", log_row[0], 9'd1);
         check("t1_row1", log_row[1], 9'd2);
         check("t1_row2", log_row[2], 9'd2);
         check("t1_row3", log_row[3], 9'd3);
         check("t1_mask0", log_mask[0], 64'hFFFF_FFFF_0000_0000);
         check("t1_mask1", log_mask[1], 64'h0000_0000_FFFF_FFFF);
         check("t1_mask2", log_mask[2], 64'hFFFF_FFFF_0000_0000);
         check("t1_mask3", log_mask[3], 64'h0000_0000_FFFF_FFFF);
      end
      check("sram_row1_hi", sram[1][63:32], 32'hAAAA_0001);
      check("sram_row2", sram[2], 64'hCCCC_0003_BBBB_0002);
      check("sram_row3_lo", sram[3][31:0], 32'hDDDD_0004);

      // read the same range back; first beat 4 cycles after the accept edge
      start_read(14'h003, 4);
      finish_read();
      check("first_read_latency", first_valid_cyc - accept_cyc, 4);

      // write burst with a 5-cycle control access before the third beat
      beat_q = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
      write_burst(14'h020, 4, 2, -1);
      check("ctl_write_landed", sram[9'h100] & 64'hFFFF_0000_FFFF_0000, 64'h0123_0000_89AB_0000);
      start_read(14'h020, 4);
      finish_read();

      // address wrap at the top of the message space
      beat_q = '{32'hEEEE_0005, 32'hFFFF_0006};
      write_burst(14'h3FF, 2, -1, -1);
      check("wrap_row1ff_hi", sram[9'h1FF][63:32], 32'hEEEE_0005);
      check("wrap_row0_lo", sram[0][31:0], 32'hFFFF_0006);
      start_read(14'h3FF, 2);
      finish_read();

      // reset during the wait of the third read beat
      base = rd_issue_cnt;
      start_read(14'h003, 4);
      w = 0;
      while (rd_issue_cnt < base + 3 && w < 100) begin
         @(negedge clk); #1;
         w++;
      end
      check("third_issue_seen", rd_issue_cnt - base, 3);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("abort_cmd_ready", cmd_ready, 1'b1);
      check("abort_spi_data_out", spi_data_out, 32'h0);
      check("abort_out_valid", spi_data_out_valid, 1'b0);
      check("abort_burst_done", burst_done, 1'b0);
      check("abort_in_ready", spi_data_in_ready, 1'b0);
      check("abort_cs", chip_select, 1'b0);
      exp_rd.delete(); exp_rd_row.delete();
      done_base = done_count;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("no_done_after_abort", done_count - done_base, 0);
      @(posedge clk); #1;

      // fresh bursts after the abort
      beat_q = '{32'h6666_0007, 32'h7777_0008};
      write_burst(14'h010, 2, -1, -1);
      check("post_reset_row8", sram[8], 64'h7777_0008_6666_0007);
      start_read(14'h010, 2);
      finish_read();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_manager_burst.md
Name: memory_manager_burst

Overview:
- Successor to the per-message memory manager: SPI-side accesses are multi-message bursts with auto-incrementing address, not single combinational accesses.
- Arbitrates the single-port SRAM between the SPI burst engine and the control datapath; control always wins a cycle it requests.
- Handles configurable SRAM read latency and extracts or inserts MESSAGE_BIT_WIDTH slices of WORD_BIT_WIDTH rows.
- Sits between the SPI command decoder and one SRAM macro; one instance per memory.

Parameters:
- WORD_BIT_WIDTH, 64, SRAM row width; must be an integer multiple of MESSAGE_BIT_WIDTH (elaboration error otherwise).
- ADDRESS_BIT_WIDTH, 9, SRAM row address width.
- START_ADDRESS_BIT_WIDTH, 14, SPI message-address width; must be >= ADDRESS_BIT_WIDTH+BITS_FOR_WITHIN_ROW (elaboration error otherwise).
- MESSAGE_BIT_WIDTH, 32, SPI message width.
- MEMORY_READ_LATENCY, 1, cycles from SRAM read issue to valid memory_data_out; must be >= 1.
- BURST_LENGTH_BIT_WIDTH, 8, width of burst-length field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- is_code_for_this_memory  in  1  SPI command targets this memory; sampled with the command.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = program burst, 0 = read burst.
- cmd_start_address  in  START_ADDRESS_BIT_WIDTH  first message address.
- cmd_burst_length  in  BURST_LENGTH_BIT_WIDTH  number of messages minus 1.
- spi_data_in  in  MESSAGE_BIT_WIDTH  write beat data.
- spi_data_in_valid  in  1  write beat valid.
- spi_data_in_ready  out  1  write beat accepted this cycle.
- spi_data_out  out  MESSAGE_BIT_WIDTH  read beat data, registered.
- spi_data_out_valid  out  1  one-cycle pulse per read beat.
- burst_done  out  1  one-cycle pulse after the last beat completes.
- memory_data_out  in  WORD_BIT_WIDTH  SRAM read data.
- control_chip_select, control_write_enable  in  1 each  control request.
- control_address  in  ADDRESS_BIT_WIDTH; control_data_in, control_mask  in  WORD_BIT_WIDTH.
- chip_select, write_enable  out  1 each; address  out  ADDRESS_BIT_WIDTH; data_in, mask  out  WORD_BIT_WIDTH  to SRAM.

Behaviour:
- Reset: FSM to IDLE; counters 0; spi_data_out 0; spi_data_out_valid, burst_done, spi_data_in_ready 0; cmd_ready 1. SRAM outputs pass control inputs through.
- Command accept (IDLE, cmd_valid & is_code_for_this_memory): latch start address (low ADDRESS_BIT_WIDTH+BITS_FOR_WITHIN_ROW bits) and remaining = cmd_burst_length; go to WRITE or READ_ISSUE. cmd_valid with code low is ignored.
- Message address split: low BITS_FOR_WITHIN_ROW bits give the slice; the next ADDRESS_BIT_WIDTH bits give the row. Increment is modulo 2^(ADDRESS_BIT_WIDTH+BITS_FOR_WITHIN_ROW), so the address wraps to 0.
- SPI slot: free when control_chip_select=0. Otherwise the SRAM bus carries control signals unchanged and the SPI beat stalls.
- WRITE: spi_data_in_ready = spi_data_in_valid & slot free. On acceptance, in the same cycle: cs=1, we=1, address=row, data_in = data << slice*MESSAGE_BIT_WIDTH, mask = all-ones message << same; address++. If remaining==0, pulse burst_done next cycle and go to IDLE; else remaining--.
- READ_ISSUE: when the slot is free, cs=1, we=0, address=row; capture the slice index; go to READ_WAIT.
- READ_WAIT: count MEMORY_READ_LATENCY cycles. On the final one, register the slice of memory_data_out into spi_data_out with spi_data_out_valid=1 the following cycle. Control may use the SRAM during this wait. Then go to READ_ISSUE (address++, remaining--) or to IDLE with burst_done.
- Only one read is outstanding; there is no output backpressure.
- Read beats are spaced MEMORY_READ_LATENCY+1 cycles minimum, plus stall cycles.
- A control write to the row being burst-read is not hazard-checked; software owns ordering.
- rst_n low mid-burst aborts immediately: no further SRAM access and no burst_done.

Decomposition:
- Shared package memory_manager_pkg holds:
  - the derived constants NUM_MESSAGES_IN_WORD, BITS_FOR_WITHIN_ROW, REQUIRED_SHIFT;
  - the FSM state encoding IDLE/WRITE/READ_ISSUE/READ_WAIT.
- One sub-module, message_slicer: combinational insert (data/mask shift) and extract (data_out shift/truncate) by slice index. It is reusable by other managers.

Test Plan (defaults: 64/32, 2 slices per row, 10-bit message address space):
- Write burst start 0x003, length 3, data A,B,C,D, no control -> four SRAM writes:
  - row1 mask 0xFFFFFFFF_00000000;
  - row2 lower;
  - row2 upper;
  - row3 lower.
  Each data is aligned to its mask, and burst_done pulses once.
- Read burst of the same range with MEMORY_READ_LATENCY=2 -> spi_data_out A,B,C,D. Valid pulses are at least 3 cycles apart; no write_enable is asserted.
- Write burst with control_chip_select held high for 5 cycles mid-burst:
  - SRAM sees the control access exactly;
  - spi_data_in_ready stays 0 for those cycles;
  - no beat is lost or duplicated.
- Start address 0x3FF, length 1 -> row 0x1FF upper slice, then row 0x000 lower slice (wrap).
- cmd_valid with is_code_for_this_memory=0 -> no SRAM activity and cmd_ready stays 1. A second cmd_valid while busy is not accepted.
- rst_n asserted during the READ_WAIT state of the third beat -> all outputs at reset values asynchronously, no burst_done; a new burst after reset works.
